// File: rtl/timer_pkg.sv
// Shared types and helpers for the round-robin timer scheduler.
package timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_COUNT = 3'b010,
    ST_DONE  = 3'b100
  } timer_sched_state_t;

  localparam int TIMER_DATA_WIDTH_DEFAULT = 8;

  // Sized for the largest supported requester count (16).
  function automatic logic [15:0] onehot_from_idx(input logic [3:0] idx);
    return 16'b1 << idx;
  endfunction

endpackage

// File: rtl/timer_rr_arb.sv
// Combinational round-robin picker: first requester strictly after last_grant wins.
module timer_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last_grant,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [IDW-1:0]     grant_idx,
  output logic               grant_any
);

  int cand;

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    grant_any    = 1'b0;
    cand         = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_grant) + k) % NUM_REQ;
      if (!grant_any && req[cand]) begin
        grant_any          = 1'b1;
        grant_idx          = IDW'(cand);
        grant_onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_sched.sv
// Round-robin scheduler sharing one up-counting delay timer among NUM_REQ clients.
//   state    | meaning
//   ST_IDLE  | waiting for a request, req_ready shows the arbiter winner
//   ST_COUNT | counting the accepted delay, hold freezes, abort cancels
//   ST_DONE  | one-cycle done pulse for active_id
module timer_sched
  import timer_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = TIMER_DATA_WIDTH_DEFAULT,
  parameter int IDW        = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_delay,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          hold,
  input  logic                          abort,
  output logic                          busy,
  output logic [IDW-1:0]                active_id,
  output logic [NUM_REQ-1:0]            done,
  output logic                          aborted
);

  timer_sched_state_t    state_q;
  logic [DATA_WIDTH-1:0] cnt_q;
  logic [DATA_WIDTH-1:0] delay_q;
  logic [IDW-1:0]        active_id_q;
  logic [IDW-1:0]        last_grant_q;
  logic                  aborted_q;

  logic [NUM_REQ-1:0]    grant_onehot;
  logic [IDW-1:0]        grant_idx;
  logic                  grant_any;
  logic [DATA_WIDTH-1:0] sel_delay;
  logic [DATA_WIDTH-1:0] cnt_d;

  timer_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .req          (req_valid),
    .last_grant   (last_grant_q),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .grant_any    (grant_any)
  );

  assign sel_delay = req_delay[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign cnt_d     = cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      delay_q      <= '0;
      active_id_q  <= '0;
      last_grant_q <= IDW'(NUM_REQ - 1);
      aborted_q    <= 1'b0;
    end else begin
      aborted_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (grant_any) begin
            delay_q      <= sel_delay;
            active_id_q  <= grant_idx;
            last_grant_q <= grant_idx;
            cnt_q        <= '0;
            state_q      <= (sel_delay == '0) ? ST_DONE : ST_COUNT;
          end
        end
        ST_COUNT: begin
          // Abort wins over both hold and a coincident expiry.
          if (abort) begin
            state_q   <= ST_IDLE;
            aborted_q <= 1'b1;
          end else if (!hold) begin
            cnt_q <= cnt_d;
            if (cnt_d == delay_q) state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (rst && state_q == ST_IDLE) ? grant_onehot : '0;
  assign busy      = (state_q != ST_IDLE);
  assign active_id = active_id_q;
  assign aborted   = aborted_q;
  assign done      = (state_q == ST_DONE) ? NUM_REQ'(onehot_from_idx(4'(active_id_q))) : '0;

endmodule
